fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the instruction memory: it owns the program counter, drives the memory's address and read-enable, and captures the returned word into an output register. That register feeds the decode stage over a valid/ready handshake. It also handles control-flow redirects from execute and stops fetching on EBREAK or on a fetch error.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_if.sv | 24 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, execute redirect and decode handshake.
interface fetch_if;

    logic [31:0] imem_addr;
    logic        imem_re;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        output imem_addr, imem_re, if_valid, if_instr, if_pc,
        input  imem_data, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_addr, imem_re, if_valid, if_instr, if_pc,
        output imem_data, redirect_valid, redirect_pc, if_ready
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads instruction memory and presents one
// registered instruction to decode over valid/ready; halts on EBREAK or fault.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     start,
    fetch_if.master  bus,
    output logic     halted,
    output logic     err
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        err_q, err_d;

    logic in_range;
    logic misaligned;
    logic slot_free;
    logic is_ebreak;

    assign in_range   = {2'b00, pc_q[31:2]} < IMEM_WORDS;
    assign misaligned = |bus.redirect_pc[1:0];
    assign slot_free  = !valid_q || bus.if_ready;
    assign is_ebreak  = bus.imem_data == INSTR_EBREAK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (bus.redirect_valid) begin
                    if (misaligned) state_d = HALT;
                end else if (!in_range) begin
                    state_d = HALT;
                end else if (slot_free && is_ebreak) begin
                    state_d = HALT;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.imem_re   = state_q == RUN;
        bus.imem_addr = {2'b00, pc_q[31:2]};
        bus.if_valid  = valid_q;
        bus.if_instr  = instr_q;
        bus.if_pc     = ipc_q;
        halted        = state_q == HALT;
        err           = err_q;
    end

    // Redirect outranks capture and stall; a redirect flushes even a word decode is taking.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        err_d   = err_q;
        if (valid_q && bus.if_ready) valid_d = 1'b0;
        if (state_q == RUN) begin
            if (bus.redirect_valid) begin
                valid_d = 1'b0;
                if (misaligned) err_d = 1'b1;
                else            pc_d  = bus.redirect_pc;
            end else if (!in_range) begin
                err_d = 1'b1;
            end else if (slot_free) begin
                valid_d = 1'b1;
                instr_d = bus.imem_data;
                ipc_d   = pc_q;
                if (!is_ebreak) pc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= INSTR_NOP;
            ipc_q   <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming/stall/redirect/EBREAK,
// hand sequences for misaligned and out-of-range redirects and async reset.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic halted, err;
    int   checks = 0;
    int   errors = 0;

    fetch_if bus ();
    logic [31:0] mem [256];

    assign bus.imem_data = (bus.imem_addr < 32'd256) ? mem[bus.imem_addr[7:0]] : 32'h0;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bus    (bus),
        .halted (halted),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_addr;
        logic        exp_re;
        logic        exp_halted;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic rv, input logic [31:0] rp);
        start              = s;
        bus.if_ready       = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs [15];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]  = 32'h11;
        mem[1]  = 32'h22;
        mem[2]  = 32'h33;
        mem[3]  = 32'h44;
        mem[4]  = INSTR_EBREAK;
        mem[16] = 32'h55;
        mem[17] = 32'h66;

        //         start ready redir rpc    valid pc     instr   addr  re  halt err
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,  32'd0,  1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  32'h11, 32'd1,  1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h22, 32'd2,  1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  32'h33, 32'd3,  1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h33, 32'd3,  1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h33, 32'd3,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h33, 32'd3,  1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  32'h44, 32'd4,  1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0,  32'h0,  32'd16, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'h55, 32'd17, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 32'h66, 32'd18, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0,  32'h0,  32'd4,  1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, INSTR_EBREAK, 32'd4, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,  32'd4,  1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0,  32'h0,  32'd4,  1'b0, 1'b1, 1'b0};

        do_reset();
        chk("rst_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rst_instr", bus.if_instr, INSTR_NOP);
        chk("rst_pc", bus.if_pc, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_re", {31'h0, bus.imem_re}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].start, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            step();
            chk($sformatf("v%0d_valid", i), {31'h0, bus.if_valid}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_re", i), {31'h0, bus.imem_re}, {31'h0, vecs[i].exp_re});
            chk($sformatf("v%0d_halted", i), {31'h0, halted}, {31'h0, vecs[i].exp_halted});
            chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_ifpc", i), bus.if_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d_instr", i), bus.if_instr, vecs[i].exp_instr);
            end
        end

        // Misaligned redirect: pc kept, error and halt on the same edge.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("mis_pre_pc", bus.if_pc, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h42);
        step();
        chk("mis_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("mis_err", {31'h0, err}, 32'h1);
        chk("mis_halted", {31'h0, halted}, 32'h1);
        chk("mis_addr", bus.imem_addr, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("mis_err_sticky", {31'h0, err}, 32'h1);

        // Aligned redirect past the end of memory: faults without capturing.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b1, 32'h400);
        step();
        chk("oor_redir_halted", {31'h0, halted}, 32'h0);
        chk("oor_redir_addr", bus.imem_addr, 32'd256);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("oor_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("oor_err", {31'h0, err}, 32'h1);
        chk("oor_halted", {31'h0, halted}, 32'h1);
        chk("oor_re", {31'h0, bus.imem_re}, 32'h0);

        // Async reset mid-stream drops the in-flight word immediately.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("mid_pre_valid", {31'h0, bus.if_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("mid_instr", bus.if_instr, INSTR_NOP);
        chk("mid_ifpc", bus.if_pc, 32'h0);
        chk("mid_addr", bus.imem_addr, 32'h0);
        chk("mid_re", {31'h0, bus.imem_re}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        step();
        chk("idle_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("idle_re", {31'h0, bus.imem_re}, 32'h0);
        chk("idle_addr", bus.imem_addr, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("restart_valid", {31'h0, bus.if_valid}, 32'h0);
        step();
        chk("restart_ifpc", bus.if_pc, 32'h0);
        chk("restart_instr", bus.if_instr, 32'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
